// File: rtl/bus1_arbiter.sv
// bus1_arbiter
//
// Shares the cache bus-1 port between two CPU-side requesters (for example
// instruction fetch and data access). A round-robin arbiter picks a winner
// in IDLE and latches its command. The block then drives the two-cycle issue
// phase (address high part, then offset) and releases the bus. It waits for
// a RESPONSE code on C1 or for a timeout, and returns read data to the
// winning port with a one-cycle DONE pulse. Every output is registered. The
// tri-state resolution of C1/A1/D1 happens one level up; this block only
// produces value/enable pairs and observes the resolved buses.
//
// Ports
//   CLK, RESET            clock (posedge), asynchronous active-low reset
//   Rn_VALID/CMD/ADDR/WDATA   request from port n (held until Rn_READY)
//   Rn_READY              one-cycle pulse when port n's request is latched
//   Rn_DONE/RDATA/ERR     completion pulse, read data (held), timeout flag
//   C1_O/C1_OE            command value / drive enable
//   A1_O/A1_OE            address value / drive enable
//   D1_O/D1_OE            data value / drive enable
//   C1_I, D1_I            resolved C1 and D1 buses

module bus1_arbiter #(
    parameter int CACHE_ADDR_SIZE   = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA_BUS_SIZE     = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         CLK,
    input  logic                         RESET,

    input  logic                         R0_VALID,
    input  logic [CTR1_BUS_SIZE-1:0]     R0_CMD,
    input  logic [CACHE_ADDR_SIZE-1:0]   R0_ADDR,
    input  logic [2*DATA_BUS_SIZE-1:0]   R0_WDATA,
    output logic                         R0_READY,
    output logic                         R0_DONE,
    output logic [2*DATA_BUS_SIZE-1:0]   R0_RDATA,
    output logic                         R0_ERR,

    input  logic                         R1_VALID,
    input  logic [CTR1_BUS_SIZE-1:0]     R1_CMD,
    input  logic [CACHE_ADDR_SIZE-1:0]   R1_ADDR,
    input  logic [2*DATA_BUS_SIZE-1:0]   R1_WDATA,
    output logic                         R1_READY,
    output logic                         R1_DONE,
    output logic [2*DATA_BUS_SIZE-1:0]   R1_RDATA,
    output logic                         R1_ERR,

    output logic [CTR1_BUS_SIZE-1:0]     C1_O,
    output logic                         C1_OE,
    output logic [ADDR1_BUS_SIZE-1:0]    A1_O,
    output logic                         A1_OE,
    output logic [DATA_BUS_SIZE-1:0]     D1_O,
    output logic                         D1_OE,
    input  logic [CTR1_BUS_SIZE-1:0]     C1_I,
    input  logic [DATA_BUS_SIZE-1:0]     D1_I
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last counter value of the WAIT window; the edge leaving it expires the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [CTR1_BUS_SIZE-1:0] CMD_NOP      = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ8    = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ16   = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32   = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE8   = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE32  = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_RESPONSE = CTR1_BUS_SIZE'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_ISSUE2,
        ST_WAIT,
        ST_RESP2,
        ST_GAP
    } state_t;

    state_t                        state;
    logic                          last;      // port granted most recently
    logic                          owner;     // port owning the current transaction
    logic [CTR1_BUS_SIZE-1:0]      cmd_q;
    logic [CACHE_ADDR_SIZE-1:0]    addr_q;
    logic [2*DATA_BUS_SIZE-1:0]    wdata_q;
    logic [CNT_W-1:0]              cnt;
    logic [DATA_BUS_SIZE-1:0]      resp_lo;   // first READ32 word, staged until DONE

    // ------------------------------------------------------------------
    // Command classification helpers
    // ------------------------------------------------------------------
    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] c);
        return (c >= CMD_WRITE8);
    endfunction

    function automatic logic is_read(input logic [CTR1_BUS_SIZE-1:0] c);
        return (c == CMD_READ8) || (c == CMD_READ16) || (c == CMD_READ32);
    endfunction

    // Single-word read result: READ8 keeps only the low byte, READ16 the word.
    function automatic logic [2*DATA_BUS_SIZE-1:0] fmt_read(
        input logic [CTR1_BUS_SIZE-1:0] c,
        input logic [DATA_BUS_SIZE-1:0] d
    );
        logic [2*DATA_BUS_SIZE-1:0] r;
        r = {{DATA_BUS_SIZE{1'b0}}, d};
        if (c == CMD_READ8) begin
            r = {{(2*DATA_BUS_SIZE-8){1'b0}}, d[7:0]};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Round-robin selection (combinational, used only in IDLE)
    // ------------------------------------------------------------------
    logic                          elig0;
    logic                          elig1;
    logic                          grant_valid;
    logic                          grant_sel;
    logic [CTR1_BUS_SIZE-1:0]      sel_cmd;
    logic [CACHE_ADDR_SIZE-1:0]    sel_addr;
    logic [2*DATA_BUS_SIZE-1:0]    sel_wdata;

    always_comb begin
        elig0       = R0_VALID && (R0_CMD != CMD_NOP);
        elig1       = R1_VALID && (R1_CMD != CMD_NOP);
        grant_valid = elig0 || elig1;
        // On a tie the port that did not win last time goes first.
        grant_sel   = (elig0 && elig1) ? ~last : elig1;
        sel_cmd     = R0_CMD;
        sel_addr    = R0_ADDR;
        sel_wdata   = R0_WDATA;
        if (grant_sel) begin
            sel_cmd   = R1_CMD;
            sel_addr  = R1_ADDR;
            sel_wdata = R1_WDATA;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM with registered bus and handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            resp_lo  <= '0;
            C1_O     <= '0;
            C1_OE    <= 1'b0;
            A1_O     <= '0;
            A1_OE    <= 1'b0;
            D1_O     <= '0;
            D1_OE    <= 1'b0;
            R0_READY <= 1'b0;
            R1_READY <= 1'b0;
            R0_DONE  <= 1'b0;
            R1_DONE  <= 1'b0;
            R0_ERR   <= 1'b0;
            R1_ERR   <= 1'b0;
            R0_RDATA <= '0;
            R1_RDATA <= '0;
        end else begin
            // Handshake outputs are single-cycle pulses by default.
            R0_READY <= 1'b0;
            R1_READY <= 1'b0;
            R0_DONE  <= 1'b0;
            R1_DONE  <= 1'b0;
            R0_ERR   <= 1'b0;
            R1_ERR   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner   <= grant_sel;
                        last    <= grant_sel;
                        cmd_q   <= sel_cmd;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (grant_sel) R1_READY <= 1'b1;
                        else           R0_READY <= 1'b1;
                        // Outputs are registered, so ISSUE1 values load on the grant edge.
                        C1_O  <= sel_cmd;
                        C1_OE <= 1'b1;
                        A1_O  <= sel_addr[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
                        A1_OE <= 1'b1;
                        D1_OE <= is_write(sel_cmd);
                        D1_O  <= is_write(sel_cmd) ? sel_wdata[DATA_BUS_SIZE-1:0]
                                                   : '0;
                        state <= ST_ISSUE1;
                    end
                end

                ST_ISSUE1: begin
                    // Second issue cycle carries the zero-extended offset.
                    A1_O <= {{(ADDR1_BUS_SIZE-CACHE_OFFSET_SIZE){1'b0}},
                             addr_q[CACHE_OFFSET_SIZE-1:0]};
                    if (cmd_q == CMD_WRITE32) begin
                        D1_O <= wdata_q[2*DATA_BUS_SIZE-1:DATA_BUS_SIZE];
                    end else if (is_write(cmd_q)) begin
                        D1_O <= wdata_q[DATA_BUS_SIZE-1:0];
                    end else begin
                        D1_O <= '0;
                    end
                    state <= ST_ISSUE2;
                end

                ST_ISSUE2: begin
                    // Release the bus so the cache can drive its response.
                    C1_O  <= '0;
                    C1_OE <= 1'b0;
                    A1_O  <= '0;
                    A1_OE <= 1'b0;
                    D1_O  <= '0;
                    D1_OE <= 1'b0;
                    cnt   <= '0;
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A response wins over a timeout expiring on the same edge.
                    if (C1_I == CMD_RESPONSE) begin
                        if (cmd_q == CMD_READ32) begin
                            resp_lo <= D1_I;
                            state   <= ST_RESP2;
                        end else begin
                            if (owner) begin
                                R1_DONE <= 1'b1;
                                if (is_read(cmd_q)) R1_RDATA <= fmt_read(cmd_q, D1_I);
                            end else begin
                                R0_DONE <= 1'b1;
                                if (is_read(cmd_q)) R0_RDATA <= fmt_read(cmd_q, D1_I);
                            end
                            state <= ST_GAP;
                        end
                    end else if (cnt == CNT_LAST) begin
                        if (owner) begin
                            R1_DONE <= 1'b1;
                            R1_ERR  <= 1'b1;
                        end else begin
                            R0_DONE <= 1'b1;
                            R0_ERR  <= 1'b1;
                        end
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP2: begin
                    if (owner) begin
                        R1_DONE  <= 1'b1;
                        R1_RDATA <= {D1_I, resp_lo};
                    end else begin
                        R0_DONE  <= 1'b1;
                        R0_RDATA <= {D1_I, resp_lo};
                    end
                    state <= ST_GAP;
                end

                ST_GAP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus1_arbiter.sv
// tb_bus1_arbiter
//
// Directed bench for bus1_arbiter built with TIMEOUT_CYCLES = 8. The bench
// plays the cache side by driving C1_I/D1_I itself. Single-requester
// transactions come from a vector table; tie arbitration and reset during
// WAIT are exercised by hand-written sequences.

module tb_bus1_arbiter;

    logic        CLK;
    logic        RESET;
    logic        R0_VALID, R1_VALID;
    logic [2:0]  R0_CMD, R1_CMD;
    logic [18:0] R0_ADDR, R1_ADDR;
    logic [31:0] R0_WDATA, R1_WDATA;
    logic        R0_READY, R1_READY, R0_DONE, R1_DONE, R0_ERR, R1_ERR;
    logic [31:0] R0_RDATA, R1_RDATA;
    logic [2:0]  C1_O, C1_I;
    logic [14:0] A1_O;
    logic [15:0] D1_O, D1_I;
    logic        C1_OE, A1_OE, D1_OE;

    int checks   = 0;
    int failures = 0;

    bus1_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .R0_VALID(R0_VALID), .R0_CMD(R0_CMD), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
        .R0_READY(R0_READY), .R0_DONE(R0_DONE), .R0_RDATA(R0_RDATA), .R0_ERR(R0_ERR),
        .R1_VALID(R1_VALID), .R1_CMD(R1_CMD), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
        .R1_READY(R1_READY), .R1_DONE(R1_DONE), .R1_RDATA(R1_RDATA), .R1_ERR(R1_ERR),
        .C1_O(C1_O), .C1_OE(C1_OE), .A1_O(A1_O), .A1_OE(A1_OE),
        .D1_O(D1_O), .D1_OE(D1_OE), .C1_I(C1_I), .D1_I(D1_I)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        port;
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        int          resp_at;   // WAIT cycle (1-based) carrying RESPONSE; 0 = never
        logic [15:0] d_lo;
        logic [15:0] d_hi;
        logic [14:0] a1a;
        logic [14:0] a1b;
        logic        doe;
        logic [15:0] d1a;
        logic [15:0] d1b;
        int          done_at;   // WAIT-loop step at which DONE appears
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int   ready_at;
        int   done_at;
        logic other_done;
        ready_at   = 0;
        done_at    = 0;
        other_done = 1'b0;
        C1_I = 3'd0;
        D1_I = 16'd0;
        if (v.port) begin
            R1_VALID = 1'b1; R1_CMD = v.cmd; R1_ADDR = v.addr; R1_WDATA = v.wdata;
        end else begin
            R0_VALID = 1'b1; R0_CMD = v.cmd; R0_ADDR = v.addr; R0_WDATA = v.wdata;
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            if ((v.port ? R1_READY : R0_READY) === 1'b1) begin
                ready_at = i;
                break;
            end
        end
        chk("grant_latency", 32'(ready_at), 32'd1);
        chk("ready_other", 32'(v.port ? R0_READY : R1_READY), 32'd0);
        R0_VALID = 1'b0;
        R1_VALID = 1'b0;
        // ISSUE1
        chk("issue1_c1", 32'(C1_O), 32'(v.cmd));
        chk("issue1_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'({2'b11, v.doe}));
        chk("issue1_a1", 32'(A1_O), 32'(v.a1a));
        if (v.doe) chk("issue1_d1", 32'(D1_O), 32'(v.d1a));
        step();
        // ISSUE2
        chk("issue2_c1", 32'(C1_O), 32'(v.cmd));
        chk("issue2_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'({2'b11, v.doe}));
        chk("issue2_a1", 32'(A1_O), 32'(v.a1b));
        if (v.doe) chk("issue2_d1", 32'(D1_O), 32'(v.d1b));
        step();
        // WAIT
        chk("wait_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);
        for (int w = 1; w <= 20; w++) begin
            if (v.resp_at != 0 && w == v.resp_at) begin
                C1_I = 3'd7;
                D1_I = v.d_lo;
            end else if (v.resp_at != 0 && v.cmd == 3'd3 && w == v.resp_at + 1) begin
                C1_I = 3'd0;
                D1_I = v.d_hi;
            end
            step();
            C1_I = 3'd0;
            D1_I = 16'd0;
            if ((v.port ? R0_DONE : R1_DONE) === 1'b1) other_done = 1'b1;
            if ((v.port ? R1_DONE : R0_DONE) === 1'b1) begin
                done_at = w;
                break;
            end
        end
        chk("done_at", 32'(done_at), 32'(v.done_at));
        chk("done_other", 32'(other_done), 32'd0);
        chk("rdata", v.port ? R1_RDATA : R0_RDATA, v.rdata);
        chk("err", 32'(v.port ? R1_ERR : R0_ERR), 32'(v.err));
        step();
        chk("done_pulse", 32'(v.port ? R1_DONE : R0_DONE), 32'd0);
        chk("rdata_hold", v.port ? R1_RDATA : R0_RDATA, v.rdata);
    endtask

    initial begin
        int   order[3];
        int   at[3];
        int   t;
        logic seen;
        vec_t post;

        //             port cmd addr      wdata         resp d_lo     d_hi     a1a      a1b     doe d1a      d1b      done rdata         err
        vecs[0] = '{1'b0, 3'd2, 19'h12345, 32'h0,        5, 16'hBEEF, 16'h0,   15'h1234, 15'h5, 1'b0, 16'h0,   16'h0,   5, 32'h0000BEEF, 1'b0};
        vecs[1] = '{1'b1, 3'd7, 19'h00ABC, 32'hCAFEF00D, 3, 16'h0,    16'h0,   15'h00AB, 15'hC, 1'b1, 16'hF00D, 16'hCAFE, 3, 32'h00000000, 1'b0};
        vecs[2] = '{1'b0, 3'd3, 19'h7FFF0, 32'h0,        2, 16'h1111, 16'h2222, 15'h7FFF, 15'h0, 1'b0, 16'h0,   16'h0,   3, 32'h22221111, 1'b0};
        vecs[3] = '{1'b1, 3'd1, 19'h4000F, 32'h0,        1, 16'hA5C3, 16'h0,   15'h4000, 15'hF, 1'b0, 16'h0,   16'h0,   1, 32'h000000C3, 1'b0};
        vecs[4] = '{1'b0, 3'd2, 19'h00010, 32'h0,        0, 16'h0,    16'h0,   15'h0001, 15'h0, 1'b0, 16'h0,   16'h0,   8, 32'h22221111, 1'b1};
        vecs[5] = '{1'b1, 3'd5, 19'h55555, 32'h1234ABCD, 8, 16'h0,    16'h0,   15'h5555, 15'h5, 1'b1, 16'hABCD, 16'hABCD, 8, 32'h000000C3, 1'b0};
        vecs[6] = '{1'b0, 3'd6, 19'h00001, 32'hFFFF0001, 4, 16'h0,    16'h0,   15'h0000, 15'h1, 1'b1, 16'h0001, 16'h0001, 4, 32'h22221111, 1'b0};
        vecs[7] = '{1'b1, 3'd4, 19'h3ABCD, 32'h0,        2, 16'h0,    16'h0,   15'h3ABC, 15'hD, 1'b0, 16'h0,   16'h0,   2, 32'h000000C3, 1'b0};
        vecs[8] = '{1'b0, 3'd1, 19'h00022, 32'h0,        6, 16'h12FE, 16'h0,   15'h0002, 15'h2, 1'b0, 16'h0,   16'h0,   6, 32'h000000FE, 1'b0};
        post    = '{1'b0, 3'd2, 19'h00020, 32'h0,        2, 16'h7777, 16'h0,   15'h0002, 15'h0, 1'b0, 16'h0,   16'h0,   2, 32'h00007777, 1'b0};

        RESET = 1'b0;
        R0_VALID = 1'b0; R0_CMD = 3'd0; R0_ADDR = '0; R0_WDATA = '0;
        R1_VALID = 1'b0; R1_CMD = 3'd0; R1_ADDR = '0; R1_WDATA = '0;
        C1_I = 3'd0; D1_I = 16'd0;
        repeat (3) step();
        RESET = 1'b1;
        step();

        // Reset state
        chk("rst_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);
        chk("rst_bus", 32'({C1_O, A1_O}), 32'd0);
        chk("rst_d1", 32'(D1_O), 32'd0);
        chk("rst_hs", 32'({R0_READY, R1_READY, R0_DONE, R1_DONE, R0_ERR, R1_ERR}), 32'd0);
        chk("rst_rdata0", R0_RDATA, 32'd0);
        chk("rst_rdata1", R1_RDATA, 32'd0);

        // Tie arbitration over three rounds with both requesters held valid.
        // No cache response, so each round ends in a timeout.
        R0_VALID = 1'b1; R0_CMD = 3'd2; R0_ADDR = 19'h00100;
        R1_VALID = 1'b1; R1_CMD = 3'd2; R1_ADDR = 19'h00200;
        t = 0;
        for (int r = 0; r < 3; r++) begin
            order[r] = 9;
            at[r]    = 0;
            for (int i = 1; i <= 30; i++) begin
                step();
                t++;
                if (R0_READY === 1'b1 || R1_READY === 1'b1) begin
                    chk("arb_ready_both", 32'(R0_READY & R1_READY), 32'd0);
                    order[r] = (R1_READY === 1'b1) ? 1 : 0;
                    at[r]    = t;
                    break;
                end
            end
            step();
            t++;
            chk("arb_ready_single", 32'(R0_READY | R1_READY), 32'd0);
        end
        chk("arb_order0", 32'(order[0]), 32'd0);
        chk("arb_order1", 32'(order[1]), 32'd1);
        chk("arb_order2", 32'(order[2]), 32'd0);
        chk("arb_spacing1", 32'(at[1] - at[0]), 32'd12);
        chk("arb_spacing2", 32'(at[2] - at[1]), 32'd12);
        R0_VALID = 1'b0;
        R1_VALID = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (R0_DONE === 1'b1) begin
                seen = 1'b1;
                chk("arb_timeout_err", 32'(R0_ERR), 32'd1);
                break;
            end
        end
        chk("arb_final_done", 32'(seen), 32'd1);
        step();

        // Single-requester transactions from the table
        for (int k = 0; k < 9; k++) begin
            run_txn(vecs[k]);
        end

        // Reset asserted while waiting for a response
        R1_VALID = 1'b1; R1_CMD = 3'd2; R1_ADDR = 19'h00300;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (R1_READY === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstw_grant", 32'(seen), 32'd1);
        R1_VALID = 1'b0;
        repeat (3) step();
        #2;
        RESET = 1'b0;
        #1;
        chk("rstw_oe", 32'({C1_OE, A1_OE, D1_OE}), 32'd0);
        chk("rstw_bus", 32'({C1_O, A1_O}), 32'd0);
        chk("rstw_rdata1", R1_RDATA, 32'd0);
        chk("rstw_rdata0", R0_RDATA, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (R0_DONE === 1'b1 || R1_DONE === 1'b1) seen = 1'b1;
        end
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (R0_DONE === 1'b1 || R1_DONE === 1'b1) seen = 1'b1;
        end
        chk("rstw_no_done", 32'(seen), 32'd0);
        run_txn(post);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
